// File: rtl/mem_rr_scheduler_pkg.sv
// Shared definitions for the memory round-robin scheduler: FSM encoding,
// wait-counter sizing and the round-robin successor helper.
package mem_pkg;

    localparam int STATE_WIDTH      = 3;
    localparam int WAIT_COUNT_WIDTH = 16;

    typedef enum logic [STATE_WIDTH-1:0] {
        IDLE           = 3'd0,
        READ_WAITING   = 3'd1,
        WRITE_WAITING  = 3'd2,
        READ_RELAYING  = 3'd3,
        WRITE_RELAYING = 3'd4
    } state_t;

    function automatic int unsigned next_index(input int unsigned index, input int unsigned count);
        return (index + 1 >= count) ? 0 : index + 1;
    endfunction

endpackage

// File: rtl/mem_rr_scheduler_rr_picker.sv
// Combinational round-robin search: first asserted request at or after the
// pointer, wrapping around the consumer set.
module rr_picker #(
    parameter int NUM_CONSUMERS = 4,
    parameter int INDEX_WIDTH   = 2
) (
    input  logic [NUM_CONSUMERS-1:0] request,
    input  logic [INDEX_WIDTH-1:0]   pointer,
    output logic                     found,
    output logic [INDEX_WIDTH-1:0]   index
);

    int unsigned candidate;

    always_comb begin
        found     = 1'b0;
        index     = '0;
        candidate = 0;
        for (int unsigned offset = 0; offset < NUM_CONSUMERS; offset++) begin
            // pointer and offset are both below NUM_CONSUMERS, so one subtract wraps
            candidate = 32'(pointer) + offset;
            if (candidate >= NUM_CONSUMERS) begin
                candidate = candidate - NUM_CONSUMERS;
            end
            if (!found && request[candidate[INDEX_WIDTH-1:0]]) begin
                found = 1'b1;
                index = candidate[INDEX_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_rr_scheduler.sv
// Round-robin scheduler sharing one memory read/write channel among several
// consumers, with a bounded wait for memory ready and a sticky timeout flag.
module mem_rr_scheduler
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDRESS_WIDTH  = 8,
    parameter int NUM_CONSUMERS  = 4,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int WRITE_ENABLE   = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CONSUMERS-1:0]              consumer_read_valid,
    input  logic [ADDRESS_WIDTH*NUM_CONSUMERS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]              consumer_read_ready,
    output logic [DATA_WIDTH*NUM_CONSUMERS-1:0]    consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]              consumer_write_valid,
    input  logic [ADDRESS_WIDTH*NUM_CONSUMERS-1:0] consumer_write_address,
    input  logic [DATA_WIDTH*NUM_CONSUMERS-1:0]    consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]              consumer_write_ready,
    output logic                                  mem_read_valid,
    output logic [ADDRESS_WIDTH-1:0]              mem_read_address,
    input  logic                                  mem_read_ready,
    input  logic [DATA_WIDTH-1:0]                 mem_read_data,
    output logic                                  mem_write_valid,
    output logic [ADDRESS_WIDTH-1:0]              mem_write_address,
    output logic [DATA_WIDTH-1:0]                 mem_write_data,
    input  logic                                  mem_write_ready,
    output logic                                  busy,
    output logic [$clog2(NUM_CONSUMERS)-1:0]      grant_id,
    output logic                                  timeout_error
);

    localparam int GRANT_WIDTH = $clog2(NUM_CONSUMERS);
    localparam logic [WAIT_COUNT_WIDTH-1:0] TIMEOUT_LIMIT = WAIT_COUNT_WIDTH'(TIMEOUT_CYCLES);
    localparam bit WRITES_ON = (WRITE_ENABLE != 0);

    state_t                      state;
    state_t                      state_next;
    logic [GRANT_WIDTH-1:0]      rr_ptr;
    logic [WAIT_COUNT_WIDTH-1:0] wait_count;
    logic [NUM_CONSUMERS-1:0]    request;
    logic                        pick_found;
    logic [GRANT_WIDTH-1:0]      pick_index;
    logic                        grant_read;
    logic                        grant_write;
    logic                        mem_done;
    logic                        wait_expired;
    logic                        release_grant;

    assign request = consumer_read_valid | (WRITES_ON ? consumer_write_valid : '0);

    rr_picker #(
        .NUM_CONSUMERS(NUM_CONSUMERS),
        .INDEX_WIDTH  (GRANT_WIDTH)
    ) picker (
        .request(request),
        .pointer(rr_ptr),
        .found  (pick_found),
        .index  (pick_index)
    );

    // Per-state decisions shared by the next-state logic and the datapath.
    always_comb begin
        grant_read    = 1'b0;
        grant_write   = 1'b0;
        mem_done      = 1'b0;
        wait_expired  = 1'b0;
        release_grant = 1'b0;
        case (state)
            IDLE: begin
                grant_read  = pick_found && consumer_read_valid[pick_index];
                grant_write = WRITES_ON && pick_found && !consumer_read_valid[pick_index];
            end
            READ_WAITING: begin
                mem_done     = mem_read_ready;
                wait_expired = !mem_read_ready && (wait_count == TIMEOUT_LIMIT);
            end
            WRITE_WAITING: begin
                mem_done     = mem_write_ready;
                wait_expired = !mem_write_ready && (wait_count == TIMEOUT_LIMIT);
            end
            READ_RELAYING:  release_grant = !consumer_read_valid[grant_id];
            WRITE_RELAYING: release_grant = !consumer_write_valid[grant_id];
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_read) begin
                    state_next = READ_WAITING;
                end else if (grant_write) begin
                    state_next = WRITE_WAITING;
                end
            end
            READ_WAITING: begin
                if (mem_done || wait_expired) state_next = READ_RELAYING;
            end
            WRITE_WAITING: begin
                if (mem_done || wait_expired) state_next = WRITE_RELAYING;
            end
            READ_RELAYING, WRITE_RELAYING: begin
                if (release_grant) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr               <= '0;
            grant_id             <= '0;
            wait_count           <= '0;
            timeout_error        <= 1'b0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_read_data   <= '0;
            consumer_write_ready <= '0;
        end else begin
            if (grant_read || grant_write) begin
                grant_id   <= pick_index;
                rr_ptr     <= GRANT_WIDTH'(next_index(32'(pick_index), NUM_CONSUMERS));
                wait_count <= '0;
            end
            if (grant_read) begin
                mem_read_valid   <= 1'b1;
                mem_read_address <= consumer_read_address[int'(pick_index)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            end
            if (grant_write) begin
                mem_write_valid   <= 1'b1;
                mem_write_address <= consumer_write_address[int'(pick_index)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                mem_write_data    <= consumer_write_data[int'(pick_index)*DATA_WIDTH +: DATA_WIDTH];
            end

            // A timeout completes the transfer like a ready would, but with zero read data.
            if (state == READ_WAITING && (mem_done || wait_expired)) begin
                mem_read_valid                                          <= 1'b0;
                consumer_read_ready[grant_id]                           <= 1'b1;
                consumer_read_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] <= mem_done ? mem_read_data : '0;
            end
            if (state == WRITE_WAITING && (mem_done || wait_expired)) begin
                mem_write_valid                <= 1'b0;
                consumer_write_ready[grant_id] <= 1'b1;
            end
            if (wait_expired) begin
                timeout_error <= 1'b1;
            end else if ((state == READ_WAITING || state == WRITE_WAITING) && !mem_done) begin
                wait_count <= wait_count + 1'b1;
            end

            if (release_grant) begin
                if (state == READ_RELAYING) begin
                    consumer_read_ready[grant_id] <= 1'b0;
                end else begin
                    consumer_write_ready[grant_id] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_rr_scheduler.sv
// Bench for mem_rr_scheduler: table of single transactions plus hand-written
// arbitration, priority, reset-abort and write-disabled sequences.
module tb_mem_rr_scheduler;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NC = 4;
    localparam int TO = 8;

    logic clk;
    logic reset;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]    consumer_read_valid;
    logic [AW*NC-1:0] consumer_read_address;
    logic [NC-1:0]    consumer_read_ready;
    logic [DW*NC-1:0] consumer_read_data;
    logic [NC-1:0]    consumer_write_valid;
    logic [AW*NC-1:0] consumer_write_address;
    logic [DW*NC-1:0] consumer_write_data;
    logic [NC-1:0]    consumer_write_ready;
    logic             mem_read_valid;
    logic [AW-1:0]    mem_read_address;
    logic             mem_read_ready;
    logic [DW-1:0]    mem_read_data;
    logic             mem_write_valid;
    logic [AW-1:0]    mem_write_address;
    logic [DW-1:0]    mem_write_data;
    logic             mem_write_ready;
    logic             busy;
    logic [1:0]       grant_id;
    logic             timeout_error;

    logic [NC-1:0]    d2_read_valid;
    logic [AW*NC-1:0] d2_read_address;
    logic [NC-1:0]    d2_read_ready;
    logic [DW*NC-1:0] d2_read_data;
    logic [NC-1:0]    d2_write_valid;
    logic [AW*NC-1:0] d2_write_address;
    logic [DW*NC-1:0] d2_write_data;
    logic [NC-1:0]    d2_write_ready;
    logic             d2_mem_read_valid;
    logic [AW-1:0]    d2_mem_read_address;
    logic             d2_mem_write_valid;
    logic [AW-1:0]    d2_mem_write_address;
    logic [DW-1:0]    d2_mem_write_data;
    logic             d2_busy;
    logic [1:0]       d2_grant_id;
    logic             d2_timeout_error;

    mem_rr_scheduler #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CONSUMERS(NC),
        .TIMEOUT_CYCLES(TO), .WRITE_ENABLE(1)
    ) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(consumer_read_valid), .consumer_read_address(consumer_read_address),
        .consumer_read_ready(consumer_read_ready), .consumer_read_data(consumer_read_data),
        .consumer_write_valid(consumer_write_valid), .consumer_write_address(consumer_write_address),
        .consumer_write_data(consumer_write_data), .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .busy(busy), .grant_id(grant_id), .timeout_error(timeout_error)
    );

    mem_rr_scheduler #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_CONSUMERS(NC),
        .TIMEOUT_CYCLES(TO), .WRITE_ENABLE(0)
    ) dut_nowrite (
        .clk(clk), .reset(reset),
        .consumer_read_valid(d2_read_valid), .consumer_read_address(d2_read_address),
        .consumer_read_ready(d2_read_ready), .consumer_read_data(d2_read_data),
        .consumer_write_valid(d2_write_valid), .consumer_write_address(d2_write_address),
        .consumer_write_data(d2_write_data), .consumer_write_ready(d2_write_ready),
        .mem_read_valid(d2_mem_read_valid), .mem_read_address(d2_mem_read_address),
        .mem_read_ready(1'b0), .mem_read_data(16'h0000),
        .mem_write_valid(d2_mem_write_valid), .mem_write_address(d2_mem_write_address),
        .mem_write_data(d2_mem_write_data), .mem_write_ready(1'b1),
        .busy(d2_busy), .grant_id(d2_grant_id), .timeout_error(d2_timeout_error)
    );

    typedef struct {
        int          consumer;
        bit          is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        int          consumer;
        bit          is_write;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int          latency;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[7];
    logic [DW-1:0] model_rdata[NC];
    bit            model_timeout;
    int            passed;
    int            total;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [DW*NC-1:0] packed_model();
        logic [DW*NC-1:0] v;
        v = '0;
        for (int c = 0; c < NC; c++) v[c*DW +: DW] = model_rdata[c];
        return v;
    endfunction

    task automatic drive_request(input int c, input bit w, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data, input bit push);
        exp_t e;
        if (w) begin
            consumer_write_valid[c]          = 1'b1;
            consumer_write_address[c*AW +: AW] = addr;
            consumer_write_data[c*DW +: DW]    = data;
        end else begin
            consumer_read_valid[c]          = 1'b1;
            consumer_read_address[c*AW +: AW] = addr;
        end
        e.consumer = c;
        e.is_write = w;
        e.addr     = addr;
        e.data     = data;
        if (push) sb.push_back(e);
    endtask

    // Waits for the next grant, checks it against the scoreboard head, plays the
    // memory side with the given latency and completes the consumer handshake.
    task automatic serve(input int latency, input logic [DW-1:0] rdata);
        exp_t e;
        bit   seen;
        bit   timed_out;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mem_read_valid || mem_write_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("grant_seen", 64'(seen), 64'(1));
        if (!seen || sb.size() == 0) return;
        e = sb.pop_front();
        check("grant_id", 64'(grant_id), 64'(e.consumer));
        check("busy_waiting", 64'(busy), 64'(1));
        if (e.is_write) begin
            check("mem_write_req", 64'({mem_read_valid, mem_write_valid, mem_write_address, mem_write_data}),
                  64'({1'b0, 1'b1, e.addr, e.data}));
        end else begin
            check("mem_read_req", 64'({mem_write_valid, mem_read_valid, mem_read_address}),
                  64'({1'b0, 1'b1, e.addr}));
        end
        for (int cyc = 0; cyc <= TO; cyc++) begin
            if (cyc == latency) begin
                if (e.is_write) begin
                    mem_write_ready = 1'b1;
                end else begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = rdata;
                end
                @(negedge clk);
                break;
            end
            @(negedge clk);
            if (cyc < TO) begin
                if (e.is_write)
                    check("hold_write", 64'({mem_write_valid, mem_write_address, mem_write_data}),
                          64'({1'b1, e.addr, e.data}));
                else
                    check("hold_read", 64'({mem_read_valid, mem_read_address}), 64'({1'b1, e.addr}));
            end
        end
        mem_read_ready  = 1'b0;
        mem_write_ready = 1'b0;
        mem_read_data   = '0;
        timed_out = (latency > TO);
        if (timed_out) model_timeout = 1'b1;
        if (!e.is_write) model_rdata[e.consumer] = timed_out ? '0 : rdata;
        check("mem_valid_dropped", 64'({mem_read_valid, mem_write_valid}), 64'(0));
        check("timeout_error", 64'(timeout_error), 64'(model_timeout));
        check("consumer_ready", 64'({consumer_read_ready, consumer_write_ready}),
              e.is_write ? 64'(1 << e.consumer) : 64'(1 << (e.consumer + NC)));
        check("consumer_read_data", 64'(consumer_read_data), 64'(packed_model()));
        @(negedge clk);
        check("ready_held", 64'({consumer_read_ready, consumer_write_ready, busy}),
              e.is_write ? 64'(((1 << e.consumer) << 1) | 1) : 64'(((1 << (e.consumer + NC)) << 1) | 1));
        if (e.is_write) consumer_write_valid[e.consumer] = 1'b0;
        else consumer_read_valid[e.consumer] = 1'b0;
        @(negedge clk);
        check("released_idle", 64'({consumer_read_ready, consumer_write_ready, busy}), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        passed = 0;
        total  = 0;
        model_timeout = 1'b0;
        for (int c = 0; c < NC; c++) model_rdata[c] = '0;
        reset                  = 1'b1;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        mem_read_ready         = 1'b0;
        mem_read_data          = '0;
        mem_write_ready        = 1'b0;
        d2_read_valid          = '0;
        d2_read_address        = '0;
        d2_write_valid         = '0;
        d2_write_address       = '0;
        d2_write_data          = '0;

        vecs[0] = '{2, 1'b0, 8'h10, 16'hBEEF, 3};
        vecs[1] = '{0, 1'b1, 8'h44, 16'hA5A5, 0};
        vecs[2] = '{1, 1'b0, 8'h7F, 16'h1357, TO};
        vecs[3] = '{3, 1'b0, 8'hFF, 16'hFFFF, 1};
        vecs[4] = '{3, 1'b1, 8'h20, 16'h1234, 99};
        vecs[5] = '{2, 1'b0, 8'h33, 16'h9999, 50};
        vecs[6] = '{1, 1'b1, 8'h02, 16'h0001, 2};

        repeat (2) @(negedge clk);
        check("reset_ctrl", 64'({busy, grant_id, timeout_error, mem_read_valid, mem_write_valid}), 64'(0));
        check("reset_ready", 64'({consumer_read_ready, consumer_write_ready}), 64'(0));
        check("reset_mem_bus", 64'({mem_read_address, mem_write_address, mem_write_data}), 64'(0));
        check("reset_read_data", 64'(consumer_read_data), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        check("idle_after_reset", 64'({busy, d2_busy}), 64'(0));

        // All four consumers request at once: expect 0,1,2,3, then the re-request from 0.
        for (int c = 0; c < NC; c++) drive_request(c, 1'b0, 8'(8'h80 + c), '0, 1'b1);
        @(negedge clk);
        serve(2, 16'hC000);
        drive_request(0, 1'b0, 8'h90, '0, 1'b1);
        for (int k = 0; k < NC; k++) serve(1 + k, 16'(16'hC001 + k));

        // Consumer 1 read and write together: read first, write on its next win.
        drive_request(1, 1'b0, 8'h11, '0, 1'b1);
        drive_request(1, 1'b1, 8'h22, 16'h5555, 1'b1);
        @(negedge clk);
        serve(0, 16'hAAAA);
        serve(4, '0);

        foreach (vecs[i]) begin
            drive_request(vecs[i].consumer, vecs[i].is_write, vecs[i].addr, vecs[i].data, 1'b1);
            @(negedge clk);
            check("grant_latency", 64'(vecs[i].is_write ? mem_write_valid : mem_read_valid), 64'(1));
            serve(vecs[i].latency, vecs[i].data);
        end
        check("queue_drained", 64'(sb.size()), 64'(0));

        // Reset while a read is outstanding.
        drive_request(0, 1'b0, 8'h55, '0, 1'b0);
        @(negedge clk);
        check("abort_setup", 64'({mem_read_valid, busy}), 64'(2'b11));
        reset               = 1'b1;
        mem_read_ready      = 1'b1;
        mem_read_data       = 16'hDEAD;
        consumer_read_valid = '0;
        @(negedge clk);
        check("abort_ctrl", 64'({busy, grant_id, timeout_error, mem_read_valid, mem_write_valid}), 64'(0));
        check("abort_bus", 64'({consumer_read_ready, consumer_write_ready, mem_read_address,
                                mem_write_address, mem_write_data}), 64'(0));
        check("abort_read_data", 64'(consumer_read_data), 64'(0));
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ready", 64'({consumer_read_ready, busy}), 64'(0));
        end
        mem_read_ready = 1'b0;
        mem_read_data  = '0;

        // Write-disabled instance ignores a pending write entirely.
        d2_write_valid[0]       = 1'b1;
        d2_write_address[7:0]   = 8'h40;
        d2_write_data[15:0]     = 16'h7777;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("nowrite_idle", 64'({d2_mem_write_valid, d2_mem_read_valid, d2_busy, d2_write_ready,
                                       d2_read_ready, d2_mem_write_address, d2_mem_write_data}), 64'(0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_rr_scheduler.md
MEM_RR_SCHEDULER -- requirements
Module: mem_rr_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, data bits per transfer.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8, address bits.
REQ-003 SHALL have parameter NUM_CONSUMERS, default 4, requesters (>=2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, max wait for memory ready (1..65535).
REQ-005 SHALL have parameter WRITE_ENABLE, default 1; 0 ignores all write requests.
REQ-006 SHALL have: clk  input  1  clock; reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have: consumer_read_valid  input  NUM_CONSUMERS  read request per consumer; consumer_read_address  input  ADDRESS_WIDTH x NUM_CONSUMERS  read address.
REQ-008 SHALL have: consumer_read_ready  output  NUM_CONSUMERS  read done; consumer_read_data  output  DATA_WIDTH x NUM_CONSUMERS  read data.
REQ-009 SHALL have: consumer_write_valid  input  NUM_CONSUMERS; consumer_write_address  input  ADDRESS_WIDTH x NUM_CONSUMERS; consumer_write_data  input  DATA_WIDTH x NUM_CONSUMERS; consumer_write_ready  output  NUM_CONSUMERS.
REQ-010 SHALL have single memory channel: mem_read_valid  output  1; mem_read_address  output  ADDRESS_WIDTH; mem_read_ready  input  1; mem_read_data  input  DATA_WIDTH; mem_write_valid  output  1; mem_write_address  output  ADDRESS_WIDTH; mem_write_data  output  DATA_WIDTH; mem_write_ready  input  1.
REQ-011 SHALL have: busy  output  1  not IDLE; grant_id  output  clog2(NUM_CONSUMERS)  consumer being served; timeout_error  output  1  sticky timeout flag.

Function
REQ-012 SHALL implement FSM IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING; all transitions registered.
REQ-013 In IDLE, SHALL search consumers round-robin starting at rr_ptr; first consumer with read_valid, or (WRITE_ENABLE and write_valid), wins.
REQ-014 If winner has both read and write valid, read SHALL win.
REQ-015 On grant of consumer k at edge t: grant_id=k, rr_ptr=(k+1) mod NUM_CONSUMERS, mem_*_valid plus address (and write data) registered, visible cycle t+1; state -> *_WAITING.
REQ-016 In *_WAITING, mem valid/address/data SHALL hold stable until ready sampled high.
REQ-017 On mem_read_ready high: mem_read_valid<=0, consumer_read_data[k]<=mem_read_data, consumer_read_ready[k]<=1, -> READ_RELAYING; write analog without data, -> WRITE_RELAYING.
REQ-018 Wait counter SHALL clear on entering *_WAITING and increment each cycle without ready; upon reaching TIMEOUT_CYCLES: drop mem valid, set timeout_error, give consumer ready (read data 0), -> *_RELAYING.
REQ-019 Ready on the cycle the counter hits TIMEOUT_CYCLES SHALL count as success (no error).
REQ-020 In *_RELAYING, when consumer k deasserts its matching valid: consumer ready[k]<=0, -> IDLE; no new grant in that same cycle.
REQ-021 Ungranted consumers' ready/data SHALL stay unchanged; at most one consumer ready high at any time.
REQ-022 Requests arriving while busy SHALL wait; no request dropped; bounded wait <= NUM_CONSUMERS transactions.
REQ-023 busy SHALL be high in every non-IDLE state.
REQ-024 WRITE_ENABLE=0: mem_write_valid constant 0, consumer_write_ready constant 0.

Reset
REQ-025 On reset: state IDLE, rr_ptr 0, grant_id 0, counter 0, timeout_error 0, all valid/ready outputs 0, all address/data outputs 0.
REQ-026 Reset mid-transaction SHALL abort immediately; no consumer ready issued afterward.
REQ-027 timeout_error SHALL clear only by reset.

Structure
REQ-028 State enum and state width SHALL be in shared package mem_pkg.
REQ-029 Round-robin search SHALL be a combinational sub-module rr_picker (inputs request vector, pointer; outputs found, index).

Verification (NUM_CONSUMERS=4, TIMEOUT_CYCLES=8)
REQ-030 Consumer 2 reads addr 0x10, memory ready 3 cycles later with 0xBEEF -> mem_read_valid cycle t+1, consumer_read_ready[2]=1 with data 0xBEEF, cleared one cycle after valid drops.
REQ-031 All 4 consumers read simultaneously from reset -> grant order 0,1,2,3; then consumer 0 re-requests -> served after 3.
REQ-032 Consumer 1 read and write both valid -> read first, write next time consumer 1 wins.
REQ-033 Consumer 3 write 0x1234 to 0x20, memory never ready -> mem_write_valid drops after 8 cycles, timeout_error=1, consumer_write_ready[3]=1.
REQ-034 Reset asserted during READ_WAITING -> all outputs 0 next cycle, busy=0, no consumer ready.
REQ-035 WRITE_ENABLE=0, consumer 0 write valid -> no mem activity, busy stays 0.
